// File: rtl/mfp_ahb_ram_wait_pkg.sv
// Shared AHB-Lite codes, FSM state type and lane/alignment helpers for
// the mfp_ahb_ram_wait slave RAM.
package mfp_ahb_ram_wait_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  // Little-endian byte-lane enables for a transfer of the given size.
  // Sizes above a word are treated as a full word.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_enable = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic unaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    unaligned = (size > HSIZE_WORD) ||
                ((size == HSIZE_HALF) && addr_lo[0]) ||
                ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mfp_dual_port_ram_be.sv
// Simple dual-port RAM with one synchronous read port and one byte-enabled
// write port. Each byte lane is its own array so lane writes stay independent.
// Ports:
//   clk         clock
//   read_addr   word address sampled every edge; read_data valid next cycle
//   read_data   registered read data (old contents on a same-edge write)
//   write_en    commit write_data lanes selected by write_be at write_addr
module mfp_dual_port_ram_be #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic [ADDR_WIDTH-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0]     read_data,
  input  logic                      write_en,
  input  logic [DATA_WIDTH/8-1:0]   write_be,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge clk) begin
        if (write_en && write_be[gi])
          mem[write_addr] <= write_data[gi*8 +: 8];
        lane_rdata_reg <= mem[read_addr];
      end

      assign read_data[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/mfp_ahb_ram_wait.sv
// AHB-Lite slave RAM with pipelined address/data phases, independent read
// and write wait-state counts, byte/half/word writes and a two-cycle ERROR
// response for unaligned transfers.
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   HADDR/HSIZE/HTRANS/
//   HWRITE/HSEL            address-phase controls
//   HWDATA                 write data (data phase)
//   HRDATA/HREADY/HRESP    data-phase response
//   HBURST, HMASTLOCK,
//   HPROT, SI_Endian       accepted but unused
module mfp_ahb_ram_wait
  import mfp_ahb_ram_wait_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int READ_WAIT     = 2,
  parameter int WRITE_WAIT    = 2,
  parameter int ERR_UNALIGNED = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian
);

  localparam logic [3:0] READ_W  = 4'(READ_WAIT);
  localparam logic [3:0] WRITE_W = 4'(WRITE_WAIT);

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  pend_reg;
  logic [ADDR_WIDTH+1:0] addr_reg;
  logic [2:0]            size_reg;
  logic                  write_reg;
  logic                  fwd_reg;
  logic [31:0]           fwd_data_reg;
  logic [3:0]            fwd_be_reg;

  logic                  accept;
  logic                  addr_err;
  logic [3:0]            wait_cycles;
  logic                  commit;
  logic [3:0]            commit_be;
  logic                  same_word;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [31:0]           ram_rdata;
  wire  [31:0]           rdata_mux;
  logic                  unused;

  assign unused = &{1'b0, HBURST, HMASTLOCK, HPROT, SI_Endian, HADDR[31:ADDR_WIDTH+2]};

  assign HREADY = (state_reg == S_IDLE) || (state_reg == S_ERR2);
  assign HRESP  = ((state_reg == S_ERR1) || (state_reg == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign accept      = HREADY && HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign addr_err    = (ERR_UNALIGNED != 0) && unaligned(HSIZE, HADDR[1:0]);
  assign wait_cycles = HWRITE ? WRITE_W : READ_W;

  // A pending write finishes in the first S_IDLE cycle after its wait states.
  assign commit    = pend_reg && write_reg && (state_reg == S_IDLE);
  assign commit_be = byte_enable(size_reg, addr_reg[1:0]);
  assign same_word = (HADDR[ADDR_WIDTH+1:2] == addr_reg[ADDR_WIDTH+1:2]);

  // Look up the new address on an accepting edge; otherwise keep re-reading
  // the current one so data holds through wait states.
  assign ram_raddr = accept ? HADDR[ADDR_WIDTH+1:2] : addr_reg[ADDR_WIDTH+1:2];

  mfp_dual_port_ram_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_ram (
    .clk        (HCLK),
    .read_addr  (ram_raddr),
    .read_data  (ram_rdata),
    .write_en   (commit),
    .write_be   (commit_be),
    .write_addr (addr_reg[ADDR_WIDTH+1:2]),
    .write_data (HWDATA)
  );

  // The RAM returns pre-write contents when a read is accepted on the edge
  // that commits a write to the same word; patch the written lanes for the
  // one cycle where that stale word is visible.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      assign rdata_mux[gi*8 +: 8] = (fwd_reg && fwd_be_reg[gi]) ? fwd_data_reg[gi*8 +: 8]
                                                                 : ram_rdata[gi*8 +: 8];
    end
  endgenerate

  assign HRDATA = rdata_mux;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      pend_reg     <= 1'b0;
      addr_reg     <= '0;
      size_reg     <= 3'd0;
      write_reg    <= 1'b0;
      fwd_reg      <= 1'b0;
      fwd_data_reg <= 32'd0;
      fwd_be_reg   <= 4'd0;
    end else begin
      fwd_reg      <= accept && !HWRITE && !addr_err && commit && same_word;
      fwd_data_reg <= HWDATA;
      fwd_be_reg   <= commit_be;

      case (state_reg)
        // S_ERR2 drives HREADY high, so it accepts a new address phase too.
        S_IDLE, S_ERR2: begin
          state_reg <= S_IDLE;
          pend_reg  <= 1'b0;
          if (accept) begin
            addr_reg  <= HADDR[ADDR_WIDTH+1:0];
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
            if (addr_err) begin
              state_reg <= S_ERR1;
            end else begin
              pend_reg <= 1'b1;
              if (wait_cycles != 4'd0) begin
                state_reg <= S_WAIT;
                cnt_reg   <= wait_cycles - 4'd1;
              end
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0)
            state_reg <= S_IDLE;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        S_ERR1:  state_reg <= S_ERR2;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_ram_wait.sv
module tb_mfp_ahb_ram_wait;
  import mfp_ahb_ram_wait_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic        hmastlock, hwrite, si_endian;
  logic [3:0]  hprot;
  logic        hsel_a, hsel_b;
  logic [1:0]  htrans;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hready_a, hready_b, hresp_a, hresp_b;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // dut_a: 2/2 wait states; dut_b: zero wait states
  mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .READ_WAIT(2), .WRITE_WAIT(2), .ERR_UNALIGNED(1)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HMASTLOCK(hmastlock),
    .HPROT(hprot), .HSEL(hsel_a), .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata),
    .HWRITE(hwrite), .HRDATA(hrdata_a), .HREADY(hready_a), .HRESP(hresp_a), .SI_Endian(si_endian));

  mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .READ_WAIT(0), .WRITE_WAIT(0), .ERR_UNALIGNED(1)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HMASTLOCK(hmastlock),
    .HPROT(hprot), .HSEL(hsel_b), .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata),
    .HWRITE(hwrite), .HRDATA(hrdata_b), .HREADY(hready_b), .HRESP(hresp_b), .SI_Endian(si_endian));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One non-overlapped transfer. Reads push their expected data on the
  // address phase; the caller pops and compares.
  task automatic xfer(input bit b, input logic [31:0] addr, input logic [2:0] size, input bit wr,
                      input logic [31:0] wdata, input logic [31:0] exp, output int waits,
                      output logic [31:0] rdata, output logic resp_first, output logic resp_last);
    @(negedge clk);
    hsel_a = ~b; hsel_b = b; haddr = addr; hsize = size; hwrite = wr; htrans = HTRANS_NONSEQ;
    if (!wr) exp_q.push_back(exp);
    @(negedge clk);
    hsel_a = 1'b0; hsel_b = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
    resp_first = b ? hresp_b : hresp_a;
    waits = 0;
    while (!(b ? hready_b : hready_a) && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rdata     = b ? hrdata_b : hrdata_a;
    resp_last = b ? hresp_b : hresp_a;
    $display("xfer dut=%0d %s addr=0x%08h size=%0d wdata=0x%08h waits=%0d rdata=0x%08h resp=%0b/%0b",
             b, wr ? "WR" : "RD", addr, size, wdata, waits, rdata, resp_first, resp_last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hsel_a = 0; hsel_b = 0; htrans = HTRANS_IDLE; haddr = 0; hwdata = 0;
    hsize = HSIZE_WORD; hwrite = 0; hburst = 0; hmastlock = 0; hprot = 0; si_endian = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hready_a !== 1'b1 || hresp_a !== 1'b0) begin n_err++;
      $display("FAIL reset_a: hready=%b hresp=%b want 1/0", hready_a, hresp_a); end
    n_cmp++; if (hready_b !== 1'b1 || hresp_b !== 1'b0) begin n_err++;
      $display("FAIL reset_b: hready=%b hresp=%b want 1/0", hready_b, hresp_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_wait();
    int w; logic [31:0] rd, e; logic rf, rl;
    xfer(0, 32'h8, HSIZE_WORD, 1, 32'h11223344, 32'h0, w, rd, rf, rl);
    n_cmp++; if (w !== 2) begin n_err++; $display("FAIL wr_wait: got %0d want 2", w); end
    xfer(0, 32'h8, HSIZE_WORD, 0, 32'h0, 32'h11223344, w, rd, rf, rl);
    n_cmp++; if (w !== 2) begin n_err++; $display("FAIL rd_wait: got %0d want 2", w); end
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e || rl !== 1'b0) begin n_err++;
      $display("FAIL rd_data: got 0x%08h resp %b want 0x%08h resp 0", rd, rl, e); end
  endtask

  task automatic test_byte_lanes();
    int w; logic [31:0] rd, e; logic rf, rl;
    xfer(0, 32'h4, HSIZE_WORD, 1, 32'h0, 32'h0, w, rd, rf, rl);
    xfer(0, 32'h5, HSIZE_BYTE, 1, {4{8'hAA}}, 32'h0, w, rd, rf, rl);
    xfer(0, 32'h6, HSIZE_HALF, 1, {2{16'hBEEF}}, 32'h0, w, rd, rf, rl);
    xfer(0, 32'h4, HSIZE_WORD, 0, 32'h0, 32'hBEEFAA00, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL byte_lanes: got 0x%08h want 0x%08h", rd, e); end
    // A byte read returns the whole word
    xfer(0, 32'h7, HSIZE_BYTE, 0, 32'h0, 32'hBEEFAA00, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL byte_read: got 0x%08h want 0x%08h", rd, e); end
  endtask

  // Write then read the same word on consecutive address phases, zero waits.
  task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wdata,
                     input logic [31:0] raddr, input logic [31:0] exp, input string name);
    logic [31:0] e; bit low;
    low = 0;
    @(negedge clk);
    hsel_b = 1; haddr = waddr; hsize = wsize; hwrite = 1; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    if (!hready_b) low = 1;
    haddr = raddr; hsize = HSIZE_WORD; hwrite = 0; hwdata = wdata;
    exp_q.push_back(exp);
    @(negedge clk);
    if (!hready_b) low = 1;
    hsel_b = 0; htrans = HTRANS_IDLE;
    e = exp_q.pop_front();
    $display("xfer dut=1 B2B %s wr@0x%08h rd@0x%08h rdata=0x%08h", name, waddr, raddr, hrdata_b);
    n_cmp++; if (hrdata_b !== e) begin n_err++;
      $display("FAIL %s_data: got 0x%08h want 0x%08h", name, hrdata_b, e); end
    n_cmp++; if (low) begin n_err++; $display("FAIL %s_ready: HREADY went low, want always 1", name); end
  endtask

  task automatic test_back_to_back();
    int w; logic [31:0] rd, e; logic rf, rl;
    b2b(32'h10, HSIZE_WORD, 32'hCAFEF00D, 32'h10, 32'hCAFEF00D, "b2b_word");
    xfer(1, 32'h10, HSIZE_WORD, 0, 32'h0, 32'hCAFEF00D, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e || w !== 0) begin n_err++;
      $display("FAIL b2b_reread: got 0x%08h waits %0d want 0x%08h waits 0", rd, w, e); end
    xfer(1, 32'h14, HSIZE_WORD, 1, 32'h01020304, 32'h0, w, rd, rf, rl);
    b2b(32'h15, HSIZE_BYTE, {4{8'hFF}}, 32'h14, 32'h0102FF04, "b2b_byte");
  endtask

  task automatic test_error();
    int w, guard; logic [31:0] rd, e; logic rf, rl;
    xfer(0, 32'h0, HSIZE_WORD, 1, 32'h55667788, 32'h0, w, rd, rf, rl);
    xfer(0, 32'h2, HSIZE_WORD, 1, 32'hFFFFFFFF, 32'h0, w, rd, rf, rl);
    n_cmp++; if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin n_err++;
      $display("FAIL err_word: waits %0d resp %b/%b want 1 and 1/1", w, rf, rl); end
    xfer(0, 32'h1, HSIZE_HALF, 1, 32'hFFFFFFFF, 32'h0, w, rd, rf, rl);
    n_cmp++; if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin n_err++;
      $display("FAIL err_half: waits %0d resp %b/%b want 1 and 1/1", w, rf, rl); end
    xfer(0, 32'h0, 3'd3, 1, 32'hFFFFFFFF, 32'h0, w, rd, rf, rl);
    n_cmp++; if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin n_err++;
      $display("FAIL err_size3: waits %0d resp %b/%b want 1 and 1/1", w, rf, rl); end
    xfer(0, 32'h0, HSIZE_WORD, 0, 32'h0, 32'h55667788, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e || rl !== 1'b0) begin n_err++;
      $display("FAIL err_ram: got 0x%08h resp %b want 0x%08h resp 0", rd, rl, e); end
    // Errored read, with the next address phase presented during S_ERR2
    @(negedge clk);
    hsel_a = 1; haddr = 32'h6; hsize = HSIZE_WORD; hwrite = 0; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    htrans = HTRANS_IDLE;
    n_cmp++; if (hready_a !== 1'b0 || hresp_a !== 1'b1) begin n_err++;
      $display("FAIL err1_phase: hready=%b hresp=%b want 0/1", hready_a, hresp_a); end
    @(negedge clk);
    n_cmp++; if (hready_a !== 1'b1 || hresp_a !== 1'b1) begin n_err++;
      $display("FAIL err2_phase: hready=%b hresp=%b want 1/1", hready_a, hresp_a); end
    haddr = 32'h0; htrans = HTRANS_NONSEQ;
    exp_q.push_back(32'h55667788);
    @(negedge clk);
    hsel_a = 0; htrans = HTRANS_IDLE;
    guard = 0;
    while (!hready_a && guard < 40) begin guard++; @(negedge clk); end
    e = exp_q.pop_front();
    $display("xfer dut=0 RD-in-ERR2 addr=0x00000000 waits=%0d rdata=0x%08h resp=%0b", guard, hrdata_a, hresp_a);
    n_cmp++; if (guard !== 2 || hrdata_a !== e || hresp_a !== 1'b0) begin n_err++;
      $display("FAIL err2_accept: waits %0d data 0x%08h resp %b want 2 0x%08h 0", guard, hrdata_a, hresp_a, e); end
  endtask

  task automatic test_alias_busy();
    int w; logic [31:0] rd, e; logic rf, rl;
    xfer(0, 32'h100, HSIZE_WORD, 1, 32'h9ABCDEF0, 32'h0, w, rd, rf, rl);
    xfer(0, 32'h0, HSIZE_WORD, 0, 32'h0, 32'h9ABCDEF0, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL alias: got 0x%08h want 0x%08h", rd, e); end
    @(negedge clk);
    hsel_a = 1; haddr = 32'h0; hsize = HSIZE_WORD; hwrite = 1; htrans = HTRANS_BUSY; hwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("xfer dut=0 BUSY cycle=%0d hready=%b hresp=%b", i, hready_a, hresp_a);
      n_cmp++; if (hready_a !== 1'b1 || hresp_a !== 1'b0) begin n_err++;
        $display("FAIL busy_%0d: hready=%b hresp=%b want 1/0", i, hready_a, hresp_a); end
    end
    hsel_a = 0; htrans = HTRANS_IDLE;
    xfer(0, 32'h0, HSIZE_WORD, 0, 32'h0, 32'h9ABCDEF0, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e || w !== 2) begin n_err++;
      $display("FAIL busy_ram: got 0x%08h waits %0d want 0x%08h waits 2", rd, w, e); end
  endtask

  task automatic test_reset_mid();
    int w; logic [31:0] rd, e; logic rf, rl;
    xfer(0, 32'h20, HSIZE_WORD, 1, 32'h01234567, 32'h0, w, rd, rf, rl);
    @(negedge clk);
    hsel_a = 1; haddr = 32'h20; hsize = HSIZE_WORD; hwrite = 1; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    hsel_a = 0; htrans = HTRANS_IDLE; hwdata = 32'hDEADBEEF;
    n_cmp++; if (hready_a !== 1'b0) begin n_err++;
      $display("FAIL rst_pre: hready=%b want 0 in wait state", hready_a); end
    #1 rst_n = 1'b0;
    #1;
    $display("xfer dut=0 RESET mid-wait hready=%b hresp=%b", hready_a, hresp_a);
    n_cmp++; if (hready_a !== 1'b1 || hresp_a !== 1'b0) begin n_err++;
      $display("FAIL rst_mid: hready=%b hresp=%b want 1/0", hready_a, hresp_a); end
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 32'h20, HSIZE_WORD, 0, 32'h0, 32'h01234567, w, rd, rf, rl);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL rst_nowrite: got 0x%08h want 0x%08h", rd, e); end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_byte_lanes();
    test_back_to_back();
    test_error();
    test_alias_busy();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
